// File: rtl/encoder_pkg.sv
// Shared types and helpers for the quadrature encoder decoder.
// Pin pairs are packed as {a, b}.
package encoder_pkg;

    typedef enum logic [1:0] {
        MODE_X1 = 2'd0,
        MODE_X2 = 2'd1,
        MODE_X4 = 2'd2
    } enc_mode_t;

    // Exactly one of the two pins changed.
    function automatic logic is_legal_step(input logic [1:0] prev, input logic [1:0] cur);
        return (prev[1] ^ cur[1]) ^ (prev[0] ^ cur[0]);
    endfunction

    // Direction of a legal single-pin change on the 00->10->11->01 up sequence.
    function automatic logic step_is_up(input logic [1:0] prev, input logic [1:0] cur);
        return (prev[1] ^ cur[1]) ? (cur[1] ^ cur[0]) : ~(cur[1] ^ cur[0]);
    endfunction

endpackage

// File: rtl/encoder_debounce.sv
// Two-flop synchroniser followed by a stable-count debounce filter for one pin.
// After reset the filter seeds itself from the first synchronised sample.
module encoder_debounce #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    generate
        if (CYCLES == 0) begin : g_bypass
            assign dout = r_s2;
        end else begin : g_filter
            localparam int CW = $clog2(CYCLES + 1);
            localparam logic [CW-1:0] LP_LAST = CW'(CYCLES - 1);

            logic [1:0]    r_fill;
            logic          r_stable;
            logic [CW-1:0] r_cnt;

            // r_fill == 2 is the first cycle r_s2 holds a real pin sample, so the
            // level present at reset is adopted directly instead of being filtered in.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_fill   <= 2'd0;
                    r_stable <= 1'b0;
                    r_cnt    <= '0;
                end else if (r_fill != 2'd3) begin
                    r_fill <= r_fill + 2'd1;
                    r_cnt  <= '0;
                    if (r_fill == 2'd2) begin
                        r_stable <= r_s2;
                    end
                end else if (r_s2 == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == LP_LAST) begin
                    r_stable <= r_s2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign dout = r_stable;
        end
    endgenerate

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder/counter: synchronised and debounced pins, x1/x2/x4
// decoding, saturating or wrapping count, load, step/dir strobe and sticky error.
module quad_decoder
    import encoder_pkg::*;
#(
    parameter int          DATA_LEN        = 8,
    parameter int unsigned INC_STEP        = 1,
    parameter int unsigned MAX_VALUE       = 2**DATA_LEN - 1,
    parameter int unsigned SATURATE        = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned RESET_VALUE     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a,
    input  logic                b,
    input  logic [1:0]          mode,
    input  logic                load,
    input  logic [DATA_LEN-1:0] load_value,
    input  logic                clear_err,
    output logic [DATA_LEN-1:0] value,
    output logic                step,
    output logic                dir,
    output logic                err
);

    localparam logic [DATA_LEN:0]   LP_MAX_EXT = (DATA_LEN + 1)'(MAX_VALUE);
    localparam logic [DATA_LEN-1:0] LP_MAX     = DATA_LEN'(MAX_VALUE);
    localparam logic [DATA_LEN:0]   LP_INC     = (DATA_LEN + 1)'(INC_STEP);
    localparam logic [DATA_LEN-1:0] LP_RST     = DATA_LEN'(RESET_VALUE);

    logic                w_a_st;
    logic                w_b_st;
    logic [1:0]          w_cur;
    logic                w_a_chg;
    logic                w_b_chg;
    logic                w_illegal;
    logic                w_up;
    logic                w_count;
    logic [DATA_LEN:0]   w_sum;
    logic [DATA_LEN:0]   w_diff;
    logic [DATA_LEN-1:0] w_next;
    logic [DATA_LEN-1:0] w_load_val;

    logic [DATA_LEN-1:0] r_value;
    logic                r_step;
    logic                r_dir;
    logic                r_err;
    logic [1:0]          r_prev;
    logic                r_primed;
    logic [1:0]          r_warm;

    encoder_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .din   (a),
        .dout  (w_a_st)
    );

    encoder_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .din   (b),
        .dout  (w_b_st)
    );

    assign w_cur     = {w_a_st, w_b_st};
    assign w_a_chg   = r_prev[1] ^ w_cur[1];
    assign w_b_chg   = r_prev[0] ^ w_cur[0];
    assign w_illegal = w_a_chg & w_b_chg;
    assign w_up      = step_is_up(r_prev, w_cur);

    always_comb begin
        w_count = 1'b0;
        case (mode)
            MODE_X1: w_count = w_a_chg & ~w_b_chg & w_cur[1];
            MODE_X2: w_count = w_a_chg & ~w_b_chg;
            default: w_count = is_legal_step(r_prev, w_cur);
        endcase
    end

    // One extra bit catches carry out of the top and borrow below zero.
    assign w_sum  = {1'b0, r_value} + LP_INC;
    assign w_diff = {1'b0, r_value} - LP_INC;

    always_comb begin
        w_next = r_value;
        if (w_up) begin
            if (SATURATE != 0 && w_sum > LP_MAX_EXT) begin
                w_next = LP_MAX;
            end else begin
                w_next = w_sum[DATA_LEN-1:0];
            end
        end else begin
            if (SATURATE != 0 && w_diff[DATA_LEN]) begin
                w_next = '0;
            end else begin
                w_next = w_diff[DATA_LEN-1:0];
            end
        end
    end

    always_comb begin
        w_load_val = load_value;
        if (SATURATE != 0 && {1'b0, load_value} > LP_MAX_EXT) begin
            w_load_val = LP_MAX;
        end
    end

    // Priming waits for the synchroniser and filter seed to settle so the pin
    // level present across reset is absorbed into r_prev rather than counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value  <= LP_RST;
            r_step   <= 1'b0;
            r_dir    <= 1'b0;
            r_err    <= 1'b0;
            r_prev   <= 2'b00;
            r_primed <= 1'b0;
            r_warm   <= 2'd0;
        end else begin
            r_step <= 1'b0;
            r_prev <= w_cur;
            if (!r_primed) begin
                if (r_warm == 2'd3) begin
                    r_primed <= 1'b1;
                end else begin
                    r_warm <= r_warm + 2'd1;
                end
            end
            if (r_primed && w_illegal) begin
                r_err <= 1'b1;
            end else if (clear_err) begin
                r_err <= 1'b0;
            end
            if (load) begin
                r_value <= w_load_val;
            end else if (r_primed && w_count) begin
                r_value <= w_next;
                r_step  <= 1'b1;
                r_dir   <= w_up;
            end
        end
    end

    assign value = r_value;
    assign step  = r_step;
    assign dir   = r_dir;
    assign err   = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: three instances (plain, saturating, debounced)
// share the pin and control stimulus; each check targets one instance.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       a;
    logic       b;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_value;
    logic       clear_err;

    logic [7:0] v_x, v_s, v_d;
    logic       step_x, step_s, step_d;
    logic       dir_x, dir_s, dir_d;
    logic       err_x, err_s, err_d;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_x   = 0;
    int cnt_s   = 0;
    int cnt_d   = 0;
    int base;

    always #5 clk = ~clk;

    quad_decoder #(.DEBOUNCE_CYCLES(0)) u_x (
        .clk(clk), .reset(reset), .a(a), .b(b), .mode(mode), .load(load),
        .load_value(load_value), .clear_err(clear_err),
        .value(v_x), .step(step_x), .dir(dir_x), .err(err_x)
    );

    quad_decoder #(.SATURATE(1), .MAX_VALUE(10), .INC_STEP(3), .DEBOUNCE_CYCLES(0)) u_s (
        .clk(clk), .reset(reset), .a(a), .b(b), .mode(mode), .load(load),
        .load_value(load_value), .clear_err(clear_err),
        .value(v_s), .step(step_s), .dir(dir_s), .err(err_s)
    );

    quad_decoder #(.DEBOUNCE_CYCLES(4)) u_d (
        .clk(clk), .reset(reset), .a(a), .b(b), .mode(mode), .load(load),
        .load_value(load_value), .clear_err(clear_err),
        .value(v_d), .step(step_d), .dir(dir_d), .err(err_d)
    );

    // Step pulses are tallied at the posedge after they appear.
    always @(posedge clk) begin
        if (step_x) cnt_x++;
        if (step_s) cnt_s++;
        if (step_d) cnt_d++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pins(input logic [1:0] ab, input int hold);
        a = ab[1];
        b = ab[0];
        cycles(hold);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(10);
    endtask

    task automatic do_load(input logic [7:0] v);
        load_value = v;
        load       = 1'b1;
        cycles(1);
        load       = 1'b0;
    endtask

    initial begin
        reset = 1'b1; a = 1'b0; b = 1'b0; mode = 2'd2;
        load = 1'b0; load_value = 8'd0; clear_err = 1'b0;
        cycles(3);
        check("rst_value", v_x, 0);
        check("rst_step", step_x, 0);
        check("rst_dir", dir_x, 0);
        check("rst_err", err_x, 0);
        check("rst_value_db", v_d, 0);
        reset = 1'b0;
        cycles(10);

        // x4 full up cycle
        base = cnt_x;
        pins(2'b10, 8); pins(2'b11, 8); pins(2'b01, 8); pins(2'b00, 8);
        check("x4_value", v_x, 4);
        check("x4_steps", cnt_x - base, 4);
        check("x4_dir", dir_x, 1);
        check("x4_sat_clamp", v_s, 10);

        // x1 up cycle then down cycle
        mode = 2'd0;
        do_reset();
        base = cnt_x;
        pins(2'b10, 8);
        check("x1_up_value", v_x, 1);
        check("x1_up_dir", dir_x, 1);
        pins(2'b11, 8); pins(2'b01, 8); pins(2'b00, 8);
        check("x1_up_hold", v_x, 1);
        pins(2'b01, 8); pins(2'b11, 8); pins(2'b10, 8); pins(2'b00, 8);
        check("x1_down_value", v_x, 0);
        check("x1_down_dir", dir_x, 0);
        check("x1_steps", cnt_x - base, 2);

        // saturation on the clamped instance
        mode = 2'd2;
        base = cnt_s;
        do_load(8'd9);
        check("sat_load", v_s, 9);
        check("sat_load_step", step_s, 0);
        pins(2'b10, 8);
        check("sat_up1", v_s, 10);
        pins(2'b11, 8);
        check("sat_up2", v_s, 10);
        check("sat_steps", cnt_s - base, 2);
        check("sat_dir_up", dir_s, 1);
        do_load(8'd1);
        pins(2'b10, 8);
        check("sat_down_floor", v_s, 0);
        check("sat_dir_down", dir_s, 0);
        do_load(8'd200);
        check("sat_load_clamp", v_s, 10);
        check("wrap_load_raw", v_x, 200);

        // load coincident with a decoded step: load wins, step suppressed
        a = 1'b1; b = 1'b1;
        cycles(2);
        do_load(8'd255);
        check("load_wins_value", v_x, 255);
        check("load_wins_step", step_x, 0);
        cycles(6);
        check("load_wins_hold", v_x, 255);
        pins(2'b01, 8);
        check("wrap_up", v_x, 0);
        pins(2'b11, 8);
        check("wrap_down", v_x, 255);

        // debounce glitch rejection and latency
        pins(2'b00, 2);
        do_reset();
        base = cnt_d;
        a = 1'b1;
        cycles(3);
        a = 1'b0;
        cycles(12);
        check("db_glitch_value", v_d, 0);
        check("db_glitch_steps", cnt_d - base, 0);
        a = 1'b1;
        cycles(6);
        check("db_lat6", v_d, 0);
        cycles(1);
        check("db_lat7", v_d, 1);
        check("db_lat7_step", step_d, 1);
        check("db_dir", dir_d, 1);

        // illegal transitions, error priority, reset with pin high
        pins(2'b00, 2);
        do_reset();
        check("err_clean", err_x, 0);
        pins(2'b11, 8);
        check("err_set", err_x, 1);
        check("err_value_kept", v_x, 0);
        clear_err = 1'b1;
        cycles(1);
        clear_err = 1'b0;
        cycles(1);
        check("err_cleared", err_x, 0);
        a = 1'b0; b = 1'b0;
        cycles(2);
        clear_err = 1'b1;
        cycles(1);
        clear_err = 1'b0;
        check("err_set_wins", err_x, 1);
        cycles(4);
        check("err_sticky", err_x, 1);
        pins(2'b10, 8);
        check("pre_reset_step", v_x, 1);
        reset = 1'b1;
        cycles(2);
        base = cnt_x;
        reset = 1'b0;
        cycles(14);
        check("reprime_value", v_x, 0);
        check("reprime_steps", cnt_x - base, 0);
        check("reprime_err", err_x, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
